// File: rtl/lc3_io_pkg.sv
// Shared types and register constants for the LC-3 memory-mapped I/O devices.
package lc3_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int          DSR_READY_BIT = 15;
  localparam int          DSR_IE_BIT    = 14;
  localparam logic [15:0] DSR_RESET     = 16'h8000;

endpackage

// File: rtl/lc3_uart_tx_core.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, one stop bit.
// o_done is high during the last STOP cycle so the owner can flag ready on the same edge.
module lc3_uart_tx_core
  import lc3_io_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tx
);

  localparam int                CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_DIV - 1);

  tx_state_t        r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;

  logic w_baud_last;
  assign w_baud_last = (r_baud_cnt == CNT_LAST);

  // NOTE: every register below uses <= so all next-state terms read pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state    <= START;
            r_shift    <= i_byte;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b0;
          end
        end
        START: begin
          if (w_baud_last) begin
            r_state    <= DATA;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              // r_shift[0] is on the line; the next bit sits at [1].
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_baud_last) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == STOP) && w_baud_last;
  assign o_tx   = r_tx;

endmodule

// File: rtl/lc3_display_uart_tx.sv
// LC-3 display device: DSR/DDR registers, store accept logic and interrupt request,
// with each accepted DDR store sent as one serial frame on TX.
module lc3_display_uart_tx
  import lc3_io_pkg::DSR_READY_BIT;
  import lc3_io_pkg::DSR_IE_BIT;
  import lc3_io_pkg::DSR_RESET;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        LD_DDR,
  input  logic        LD_DSR,
  input  logic [15:0] DATA,
  output logic [15:0] DDR,
  output logic [15:0] DSR,
  output logic        DSP_INT,
  output logic        TX
);

  logic [15:0] r_dsr;
  logic [15:0] r_ddr;

  logic w_accept;
  logic w_busy;
  logic w_done;
  logic w_tx;
  logic w_unused_data;

  // Ready and the transmitter's idle state always agree; both are checked for robustness.
  assign w_accept      = LD_DDR && r_dsr[DSR_READY_BIT] && !w_busy;
  assign w_unused_data = DATA[15];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dsr <= DSR_RESET;
      r_ddr <= 16'h0000;
    end else begin
      if (LD_DSR) begin
        r_dsr[DSR_IE_BIT:0] <= DATA[DSR_IE_BIT:0];
      end
      if (w_accept) begin
        r_ddr                <= {8'h00, DATA[7:0]};
        r_dsr[DSR_READY_BIT] <= 1'b0;
      end else if (w_done) begin
        r_dsr[DSR_READY_BIT] <= 1'b1;
      end
    end
  end

  lc3_uart_tx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_core (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept),
    .i_byte  (DATA[7:0]),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_tx    (w_tx)
  );

  assign DDR     = r_ddr;
  assign DSR     = r_dsr;
  assign DSP_INT = r_dsr[DSR_READY_BIT] & r_dsr[DSR_IE_BIT];
  assign TX      = w_tx;

endmodule

// File: tb/tb_lc3_display_uart_tx.sv
// Directed bench for lc3_display_uart_tx with a per-cycle scoreboard of TX/ready/irq.
module tb_lc3_display_uart_tx;

  localparam int BAUD  = 4;
  localparam int FRAME = 10 * BAUD;

  logic        clk;
  logic        reset;
  logic        LD_DDR;
  logic        LD_DSR;
  logic [15:0] DATA;
  logic [15:0] DDR;
  logic [15:0] DSR;
  logic        DSP_INT;
  logic        TX;

  typedef struct packed {
    logic tx;
    logic rdy;
    logic irq;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  int   frame_pos;

  lc3_display_uart_tx #(
    .BAUD_DIV (BAUD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .LD_DDR  (LD_DDR),
    .LD_DSR  (LD_DSR),
    .DATA    (DATA),
    .DDR     (DDR),
    .DSR     (DSR),
    .DSP_INT (DSP_INT),
    .TX      (TX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    int s;
    s = i / BAUD;
    if (s == 0) return 1'b0;
    if (s >= 9) return 1'b1;
    return b[s-1];
  endfunction

  // Expected line/ready/irq for the 40 frame cycles plus the first idle cycle.
  task automatic push_frame(input logic [7:0] b, input logic ie);
    exp_t e;
    for (int i = 0; i < FRAME; i++) begin
      e.tx  = frame_bit(b, i);
      e.rdy = 1'b0;
      e.irq = 1'b0;
      sb.push_back(e);
    end
    e.tx  = 1'b1;
    e.rdy = 1'b1;
    e.irq = ie;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int n, input logic ie);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tx  = 1'b1;
      e.rdy = 1'b1;
      e.irq = ie;
      sb.push_back(e);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0 entries expected at least 1");
    end else begin
      e = sb.pop_front();
      check($sformatf("tx@%0d", frame_pos), {15'h0, TX}, {15'h0, e.tx});
      check($sformatf("ready@%0d", frame_pos), {15'h0, DSR[15]}, {15'h0, e.rdy});
      check($sformatf("irq@%0d", frame_pos), {15'h0, DSP_INT}, {15'h0, e.irq});
    end
    frame_pos++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      pop_check();
    end
  endtask

  task automatic strobe(input logic [15:0] d, input logic ld_dsr, input logic ie);
    DATA   = d;
    LD_DDR = 1'b1;
    LD_DSR = ld_dsr;
    push_frame(d[7:0], ie);
    frame_pos = 0;
    step();
    LD_DDR = 1'b0;
    LD_DSR = 1'b0;
    pop_check();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    frame_pos   = 0;
    reset       = 1'b0;
    LD_DDR      = 1'b0;
    LD_DSR      = 1'b0;
    DATA        = 16'h0000;

    // 1: reset state
    step();
    step();
    reset = 1'b1;
    step();
    check("rst_dsr", DSR, 16'h8000);
    check("rst_ddr", DDR, 16'h0000);
    check("rst_tx", {15'h0, TX}, 16'h0001);
    check("rst_irq", {15'h0, DSP_INT}, 16'h0000);

    // 2: frame for 0x41
    strobe(16'h1241, 1'b0, 1'b0);
    check("t2_ddr", DDR, 16'h0041);
    check("t2_dsr", DSR, 16'h0000);
    drain(FRAME);
    check("t2_dsr_end", DSR, 16'h8000);

    // 3: interrupt enable and irq masking while busy
    DATA   = 16'h7FFF;
    LD_DSR = 1'b1;
    step();
    LD_DSR = 1'b0;
    check("t3_dsr", DSR, 16'hFFFF);
    check("t3_irq", {15'h0, DSP_INT}, 16'h0001);
    strobe(16'h0055, 1'b0, 1'b1);
    check("t3_ddr", DDR, 16'h0055);
    drain(FRAME);
    check("t3_dsr_end", DSR, 16'hFFFF);

    // 4: store while busy is ignored
    strobe(16'h0041, 1'b0, 1'b1);
    drain(9);
    DATA   = 16'h0033;
    LD_DDR = 1'b1;
    drain(1);
    LD_DDR = 1'b0;
    check("t4_ddr_hold", DDR, 16'h0041);
    drain(FRAME - 10);
    push_idle(8, 1'b1);
    drain(8);
    check("t4_ddr_end", DDR, 16'h0041);

    // 5: async reset aborts a frame mid-flight
    strobe(16'h00FF, 1'b0, 1'b1);
    drain(14);
    reset = 1'b0;
    #1;
    check("t5_tx_abort", {15'h0, TX}, 16'h0001);
    check("t5_dsr_abort", DSR, 16'h8000);
    check("t5_ddr_abort", DDR, 16'h0000);
    sb.delete();
    step();
    reset = 1'b1;
    step();
    check("t5_tx_idle", {15'h0, TX}, 16'h0001);
    check("t5_dsr_idle", DSR, 16'h8000);
    strobe(16'h00A5, 1'b0, 1'b0);
    check("t5_ddr", DDR, 16'h00A5);
    drain(FRAME);

    // 6: simultaneous DDR and DSR stores
    strobe(16'h4041, 1'b1, 1'b1);
    check("t6_dsr", DSR, 16'h4041);
    check("t6_ddr", DDR, 16'h0041);
    drain(FRAME);
    check("t6_dsr_end", DSR, 16'hC041);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
